// File: rtl/set_mode_ctrl_if.sv
// Button/controller boundary for the time-setting controller: debounced button
// levels in, mode and one-cycle strobes out.
interface set_mode_ctrl_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] mode;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       blank;
    logic       set_done;

    modport master (
        output btn_mode, btn_up, btn_down,
        input  mode, inc_pulse, dec_pulse, blank, set_done
    );

    modport slave (
        input  btn_mode, btn_up, btn_down,
        output mode, inc_pulse, dec_pulse, blank, set_done
    );
endinterface

// File: rtl/set_mode_ctrl.sv
// Setting-mode FSM with press/hold auto-repeat, blink strobe and idle timeout.
//   state   | meaning
//   ST_RUN  | clock running, buttons other than mode ignored
//   ST_HOUR | hour field selected for adjustment
//   ST_MIN  | minute field selected
//   ST_SEC  | second field selected
module set_mode_ctrl #(
    parameter int unsigned LONG_CYC    = 25_000_000,
    parameter int unsigned REPEAT_CYC  = 5_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000,
    parameter int unsigned BLINK_CYC   = 12_500_000
) (
    input  logic           clk,
    input  logic           rst_n,
    set_mode_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HOUR = 2'b01,
        ST_MIN  = 2'b10,
        ST_SEC  = 2'b11
    } state_t;

    localparam logic [28:0] LONG_TC    = 29'(LONG_CYC - 1);
    localparam logic [28:0] REPEAT_TC  = 29'(REPEAT_CYC - 1);
    localparam logic [28:0] TIMEOUT_TC = 29'(TIMEOUT_CYC - 1);
    localparam logic [28:0] BLINK_TC   = 29'(BLINK_CYC - 1);

    state_t      state, state_n;
    logic        hist_mode, hist_up, hist_down;
    logic [28:0] hold_cnt, hold_n;
    logic [28:0] idle_cnt, idle_n;
    logic [28:0] blink_cnt, blink_n;
    logic        phase, phase_n;   // 0 = waiting for LONG, 1 = repeating
    logic        armed, armed_n;   // a single accepted press is being held
    logic        dir, dir_n;       // 0 = up, 1 = down
    logic        blank_q, blank_n;
    logic        inc_q, inc_n;
    logic        dec_q, dec_n;
    logic        done_q, done_n;

    logic rise_m, rise_u, rise_d, held, any_btn;
    logic [28:0] hold_tc;

    assign rise_m  = bus.btn_mode & ~hist_mode;
    assign rise_u  = bus.btn_up   & ~hist_up;
    assign rise_d  = bus.btn_down & ~hist_down;
    assign held    = dir ? bus.btn_down : bus.btn_up;
    assign any_btn = bus.btn_up | bus.btn_down;
    assign hold_tc = phase ? REPEAT_TC : LONG_TC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            hist_mode <= 1'b0;
            hist_up   <= 1'b0;
            hist_down <= 1'b0;
            hold_cnt  <= '0;
            idle_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            armed     <= 1'b0;
            dir       <= 1'b0;
            blank_q   <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            hist_mode <= bus.btn_mode;
            hist_up   <= bus.btn_up;
            hist_down <= bus.btn_down;
            hold_cnt  <= hold_n;
            idle_cnt  <= idle_n;
            blink_cnt <= blink_n;
            phase     <= phase_n;
            armed     <= armed_n;
            dir       <= dir_n;
            blank_q   <= blank_n;
            inc_q     <= inc_n;
            dec_q     <= dec_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        idle_n  = idle_cnt;
        blink_n = blink_cnt;
        phase_n = phase;
        armed_n = armed;
        dir_n   = dir;
        blank_n = blank_q;
        inc_n   = 1'b0;
        dec_n   = 1'b0;
        done_n  = 1'b0;

        if (state == ST_RUN || rise_m ||
            (!any_btn && idle_cnt == TIMEOUT_TC)) begin
            // Any mode change (or staying in RUN) restarts every timer and
            // forgets the current press, so repeat needs a fresh edge.
            hold_n  = '0;
            idle_n  = '0;
            blink_n = '0;
            phase_n = 1'b0;
            armed_n = 1'b0;
            blank_n = 1'b0;
            if (state == ST_RUN) begin
                if (rise_m)
                    state_n = ST_HOUR;
            end else if (rise_m) begin
                state_n = (state == ST_SEC) ? ST_RUN : state_t'(state + 2'd1);
                done_n  = (state == ST_SEC);
            end else begin
                state_n = ST_RUN;
                done_n  = 1'b1;
            end
        end else begin
            idle_n = any_btn ? '0 : idle_cnt + 29'd1;

            if (bus.btn_up && bus.btn_down) begin
                hold_n  = '0;
                phase_n = 1'b0;
                armed_n = 1'b0;
            end else if (rise_u || rise_d) begin
                inc_n   = rise_u;
                dec_n   = rise_d;
                hold_n  = '0;
                phase_n = 1'b0;
                armed_n = 1'b1;
                dir_n   = rise_d;
            end else if (armed && held) begin
                if (hold_cnt == hold_tc) begin
                    inc_n   = ~dir;
                    dec_n   = dir;
                    hold_n  = '0;
                    phase_n = 1'b1;
                end else begin
                    hold_n = hold_cnt + 29'd1;
                end
            end else begin
                hold_n  = '0;
                phase_n = 1'b0;
                armed_n = 1'b0;
            end

            // Keep the field visible right after each adjustment.
            if (inc_n || dec_n) begin
                blank_n = 1'b0;
                blink_n = '0;
            end else if (blink_cnt == BLINK_TC) begin
                blank_n = ~blank_q;
                blink_n = '0;
            end else begin
                blink_n = blink_cnt + 29'd1;
            end
        end
    end

    assign bus.mode      = state;
    assign bus.inc_pulse = inc_q;
    assign bus.dec_pulse = dec_q;
    assign bus.blank     = blank_q;
    assign bus.set_done  = done_q;
endmodule
